target_value_calc: RTL and testbench

- Downstream of the target network's Q-max output.
- Pairs each target-net o_q_max result with the reward and done flag of the replay sample that produced it. Those values arrive earlier, so they are buffered in an in-order FIFO.
- Computes the Bellman target y = r + GAMMA*q_max, or y = r when done=1, in signed fixed point.
- The result feeds the main network's loss/backprop stage.

---
 rtl/target_value_calc_if.sv | 29 ++
 rtl/target_value_calc.sv | 119 +++++++++++
 tb/tb_target_value_calc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/target_value_calc_if.sv
// Sample / Q-max / target bundle for target_value_calc; master drives the i_* side.
interface target_value_calc_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                  i_flush;
   logic                  i_sample_valid;
   logic [DATA_WIDTH-1:0] i_reward;
   logic                  i_done;
   logic                  o_sample_ready;
   logic                  i_q_max_valid;
   logic [DATA_WIDTH-1:0] i_q_max;
   logic                  o_target_valid;
   logic [DATA_WIDTH-1:0] o_target;
   logic [CW-1:0]         o_fifo_count;
   logic                  o_orphan_error;

   modport master (
      output i_flush, i_sample_valid, i_reward, i_done, i_q_max_valid, i_q_max,
      input  o_sample_ready, o_target_valid, o_target, o_fifo_count, o_orphan_error
   );

   modport slave (
      input  i_flush, i_sample_valid, i_reward, i_done, i_q_max_valid, i_q_max,
      output o_sample_ready, o_target_valid, o_target, o_fifo_count, o_orphan_error
   );
endinterface

// File: rtl/target_value_calc.sv
// Bellman target y = r + GAMMA*q_max (y = r when done); {reward, done} buffered in an in-order FIFO, 2-cycle pipeline.
// Define TARGET_VALUE_SAT_EN to saturate the product and sum instead of wrapping.
module target_value_calc #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FRAC_WIDTH = 16,
   parameter int                    FIFO_DEPTH = 8,
   parameter logic [DATA_WIDTH-1:0] GAMMA      = 32'h0000_E666
) (
   input logic               clk,
   input logic               rst,
   target_value_calc_if.slave bus
);
   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam int            CW       = AW + 1;
   localparam int            PW       = 2 * DATA_WIDTH;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] rew_mem_q [FIFO_DEPTH];
   logic                  done_mem_q [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          orphan_q, orphan_d;
   logic          push, pop;

   logic                  s1_vld_q, s1_done_q;
   logic [DATA_WIDTH:0]   s1_p_q, p_d;
   logic [DATA_WIDTH-1:0] s1_rew_q;
   logic                  tgt_vld_q;
   logic [DATA_WIDTH-1:0] tgt_q, tgt_d;

   logic signed [PW-1:0]           prod, prod_sh;
   logic signed [DATA_WIDTH+1:0]   rew_ext, add_ext, sum;

   // Ready is judged on the pre-pop count, so a full FIFO refuses a push even while popping.
   always_comb begin
      push     = bus.i_sample_valid && (count_q != FULL_CNT);
      pop      = bus.i_q_max_valid && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      orphan_d = orphan_q;
      if (bus.i_flush) begin
         push     = 1'b0;
         pop      = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
         if (bus.i_q_max_valid && (count_q == '0)) orphan_d = 1'b1;
      end
   end

   always_comb begin
      prod    = PW'($signed(GAMMA)) * PW'($signed(bus.i_q_max));
      prod_sh = prod >>> FRAC_WIDTH;
      p_d     = prod_sh[DATA_WIDTH:0];
`ifdef TARGET_VALUE_SAT_EN
      if (prod_sh[PW-1:DATA_WIDTH] != {(PW-DATA_WIDTH){prod_sh[DATA_WIDTH]}})
         p_d = prod_sh[PW-1] ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, {DATA_WIDTH{1'b1}}};
`endif
   end

   always_comb begin
      rew_ext = (DATA_WIDTH+2)'($signed(s1_rew_q));
      add_ext = s1_done_q ? '0 : (DATA_WIDTH+2)'($signed(s1_p_q));
      sum     = rew_ext + add_ext;
      tgt_d   = sum[DATA_WIDTH-1:0];
`ifdef TARGET_VALUE_SAT_EN
      if (sum[DATA_WIDTH+1:DATA_WIDTH-1] != {3{sum[DATA_WIDTH+1]}})
         tgt_d = sum[DATA_WIDTH+1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         orphan_q  <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_p_q    <= '0;
         s1_rew_q  <= '0;
         s1_done_q <= 1'b0;
         tgt_vld_q <= 1'b0;
         tgt_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         orphan_q  <= orphan_d;
         s1_vld_q  <= pop;
         if (pop) begin
            s1_p_q    <= p_d;
            s1_rew_q  <= rew_mem_q[rd_ptr_q];
            s1_done_q <= done_mem_q[rd_ptr_q];
         end
         tgt_vld_q <= s1_vld_q && !bus.i_flush;
         if (s1_vld_q && !bus.i_flush) tgt_q <= tgt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rew_mem_q[wr_ptr_q]  <= bus.i_reward;
         done_mem_q[wr_ptr_q] <= bus.i_done;
      end
   end

   assign bus.o_sample_ready = (count_q != FULL_CNT);
   assign bus.o_target_valid = tgt_vld_q;
   assign bus.o_target       = tgt_q;
   assign bus.o_fifo_count   = count_q;
   assign bus.o_orphan_error = orphan_q;
endmodule

// File: tb/tb_target_value_calc.sv
// Randomized + directed bench for target_value_calc against a queue-based reference model.
module tb_target_value_calc;
   localparam int          DW    = 32;
   localparam int          DEPTH = 8;
   localparam logic [31:0] GAMMA = 32'h0000_E666;

   typedef struct {
      logic [31:0] rew;
      bit          dn;
   } ent_t;

   typedef struct {
      int          due;
      logic [31:0] val;
   } pend_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   target_value_calc_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   target_value_calc #(.DATA_WIDTH(DW), .FRAC_WIDTH(16), .FIFO_DEPTH(DEPTH), .GAMMA(GAMMA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          edge_n   = 0;
   ent_t        fifo[$];
   pend_t       pend[$];
   bit          orphan_exp = 1'b0;
   logic [31:0] last_tgt   = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Bellman target from plain integer arithmetic
   function automatic logic [31:0] model_target(input logic [31:0] r, input bit d, input logic [31:0] q);
      longint prod, p, s;
      prod = longint'($signed(GAMMA)) * longint'($signed(q));
      p    = prod >>> 16;
`ifdef TARGET_VALUE_SAT_EN
      if (p > 64'sd4294967295) p = 64'sd4294967295;
      if (p < -64'sd4294967296) p = -64'sd4294967296;
`else
      p = (p <<< 31) >>> 31;
`endif
      s = longint'($signed(r)) + (d ? 64'sd0 : p);
`ifdef TARGET_VALUE_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return s[31:0];
   endfunction

   task automatic model_reset();
      fifo.delete();
      pend.delete();
      orphan_exp = 1'b0;
      last_tgt   = '0;
   endtask

   task automatic check_outputs(input bit exp_vld);
      chk("valid",  64'(bus.o_target_valid), 64'(exp_vld));
      chk("target", 64'(bus.o_target),       64'(last_tgt));
      chk("count",  64'(bus.o_fifo_count),   64'(fifo.size()));
      chk("ready",  64'(bus.o_sample_ready), 64'(fifo.size() != DEPTH));
      chk("orphan", 64'(bus.o_orphan_error), 64'(orphan_exp));
   endtask

   task automatic step(input bit fl, input bit sv, input logic [31:0] rw, input bit dn,
                       input bit qv, input logic [31:0] qm);
      bit    ready;
      bit    exp_vld;
      ent_t  e;
      pend_t pd;
      bus.i_flush        = fl;
      bus.i_sample_valid = sv;
      bus.i_reward       = rw;
      bus.i_done         = dn;
      bus.i_q_max_valid  = qv;
      bus.i_q_max        = qm;
      ready = (fifo.size() != DEPTH);
      @(posedge clk);
      #1;
      edge_n++;
      if (fl) begin
         fifo.delete();
         pend.delete();
      end else begin
         if (qv) begin
            if (fifo.size() > 0) begin
               e      = fifo.pop_front();
               pd.due = edge_n + 1;
               pd.val = model_target(e.rew, e.dn, qm);
               pend.push_back(pd);
            end else begin
               orphan_exp = 1'b1;
            end
         end
         if (sv && ready) begin
            e.rew = rw;
            e.dn  = dn;
            fifo.push_back(e);
         end
      end
      exp_vld = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
         exp_vld  = 1'b1;
         last_tgt = pend[0].val;
         void'(pend.pop_front());
      end
      check_outputs(exp_vld);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic push_s(input logic [31:0] rw, input bit dn);
      step(1'b0, 1'b1, rw, dn, 1'b0, '0);
   endtask

   task automatic pop_q(input logic [31:0] qm);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, qm);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs(1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      bus.i_flush = 0; bus.i_sample_valid = 0; bus.i_reward = '0; bus.i_done = 0;
      bus.i_q_max_valid = 0; bus.i_q_max = '0;
      rst = 1'b1;
      #1;
      check_outputs(1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      push_s(32'h0001_0000, 1'b0);
      pop_q(32'h0002_0000);
      idle(1);
      chk("tp_basic", 64'(bus.o_target), 64'h0002_CCCC);

      push_s(32'h0001_0000, 1'b1);
      pop_q(32'h7FFF_0000);
      idle(1);
      chk("tp_done", 64'(bus.o_target), 64'h0001_0000);

      push_s(32'h0000_0000, 1'b0);
      pop_q(32'hFFFF_0000);
      idle(1);
      chk("tp_neg", 64'(bus.o_target), 64'hFFFF_199A);

      push_s(32'h7FFF_0000, 1'b0);
      pop_q(32'h7FFF_0000);
      idle(1);
`ifdef TARGET_VALUE_SAT_EN
      chk("tp_sat", 64'(bus.o_target), 64'h7FFF_FFFF);
`else
      chk("tp_wrap", 64'(bus.o_target), 64'hF331_199A);
`endif
      idle(2);

      for (int i = 0; i < DEPTH; i++) push_s(32'(i) << 16, 1'(i % 3 == 0));
      chk("full_cnt", 64'(bus.o_fifo_count), 64'd8);
      chk("full_rdy", 64'(bus.o_sample_ready), 64'd0);
      push_s(32'h1234_5678, 1'b0);
      chk("drop_cnt", 64'(bus.o_fifo_count), 64'd8);
      step(1'b0, 1'b1, 32'h0BAD_0000, 1'b0, 1'b1, 32'h0001_0000);
      chk("pushpop_full", 64'(bus.o_fifo_count), 64'd7);
      for (int i = 0; i < 7; i++) pop_q(32'(i + 1) << 16);
      idle(3);
      chk("drained", 64'(bus.o_fifo_count), 64'd0);

      pop_q(32'h0003_0000);
      chk("orphan", 64'(bus.o_orphan_error), 64'd1);
      idle(3);

      for (int i = 0; i < 3; i++) push_s(32'h0000_8000, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("flush_cnt", 64'(bus.o_fifo_count), 64'd0);
      idle(2);

      push_s(32'h0005_0000, 1'b0);
      pop_q(32'h0001_0000);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("flush_inflight", 64'(bus.o_target_valid), 64'd0);
      idle(3);

      push_s(32'h0006_0000, 1'b0);
      pop_q(32'h0002_0000);
      do_reset();
      idle(4);
      chk("rst_no_valid", 64'(bus.o_target_valid), 64'd0);

      // randomized traffic: occupancy bias changes every 64 steps to reach full and empty
      for (int blk = 0; blk < 10; blk++) begin
         int pv, pq;
         pv = $urandom_range(20, 90);
         pq = $urandom_range(20, 90);
         for (int i = 0; i < 64; i++) begin
            logic [31:0] rw, qm;
            rw = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($signed($urandom_range(0, 32'h000F_FFFF)) - 32'sh0008_0000);
            qm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($signed($urandom_range(0, 32'h003F_FFFF)) - 32'sh0020_0000);
            step(1'($urandom_range(0, 60) == 0),
                 1'($urandom_range(0, 99) < pv), rw, 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 99) < pq), qm);
         end
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
